// File: rtl/apb_requester.sv
// apb_requester: buffers valid/ready commands in a small FIFO and issues them
// one at a time as APB3 transfers, returning one response per command.
// A programmable wait-state timeout aborts transfers to a stuck completer.
module apb_requester #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    // Counter only has to reach TIMEOUT_CYCLES-1; the abort fires on that cycle.
    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES == 0) ? {WAIT_W{1'b0}} : WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [ENT_W-1:0]      fifo_q [CMD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  full, empty, push, pop;
    logic [ENT_W-1:0]      head;

    assign full      = (count_q == CNT_W'(CMD_DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_q[rd_ptr_q];

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // FIFO pointer and occupancy update from push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Transfer FSM: APB phase sequencing, wait counting and response capture.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        // rsp_valid is only ever set from ACCESS, where it is already 0.
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !rsp_valid_q) begin
                    pop      = 1'b1;
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = head[ENT_W-1];
                    paddr_d  = head[ENT_W-2 -: ADDR_WIDTH];
                    pwdata_d = head[DATA_WIDTH-1:0];
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = {WAIT_W{1'b0}};
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : PRDATA;
                end else if (TIMEOUT_CYCLES != 0 && wait_q == WAIT_LAST) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are meaningless while the occupancy is zero.
    always_ff @(posedge PCLK) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // State, pointers, APB outputs and response registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Testbench for apb_requester: vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_apb_requester;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_addr = '0, PADDR;
    logic [DW-1:0] cmd_wdata = '0, PWDATA, PRDATA = '0, rsp_rdata;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic          PWRITE, PSEL, PENABLE, PREADY = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
                    .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, then inputs change.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic          cv, cw;
        logic [7:0]    ca, cd;
        logic          pr;
        logic [7:0]    prd;
        logic          rr;
        logic          e_psel, e_pen, e_pw;
        logic [7:0]    e_paddr, e_pwdata;
        logic          e_rv;
        logic [7:0]    e_rd;
        logic          e_re, e_crdy;
    } vec_t;

    typedef struct { logic w; logic [7:0] a; logic [7:0] d; } cmd_t;
    typedef struct { logic err; logic [7:0] rd; } rsp_t;

    vec_t        vt [14];
    cmd_t        acc_q [$];
    rsp_t        exp_q [$];
    cmd_t        cm;
    rsp_t        er;
    logic [7:0]  cmem [256];
    logic [7:0]  rmem [256];
    int          cur_w, acc_cnt, nrsp, setups, n_acc;
    logic [29:0] act_w, exp_w;

    // Observe a SETUP phase during the FIFO-full test and check issue order.
    task automatic obs_setup();
        if (PSEL && !PENABLE) begin
            chk("full_order", 32'(PADDR), 32'(8'h40 + setups[7:0]));
            setups++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin
        //            cv    cw    ca     cd     pr    prd    rr  | psel  pen   pw    paddr  pwdata rv    rd     re    crdy
        vt[0]  = '{1'b1, 1'b1, 8'h10, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};

        // ---- reset state (held in reset across two edges) ----
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_state", 32'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready, PADDR, PWDATA, rsp_rdata}),
            32'({6'b000001, 24'h0}));
        @(negedge PCLK);
        PRESET = 1'b0;

        // ---- vector table: single write then read with two wait states ----
        for (int i = 0; i < 14; i++) begin
            tick();
            act_w = {PSEL, PENABLE, PWRITE, rsp_valid, cmd_ready, PADDR,
                     vt[i].e_pw ? PWDATA : 8'h00,
                     vt[i].e_rv ? {rsp_err, rsp_rdata} : 9'h000};
            exp_w = {vt[i].e_psel, vt[i].e_pen, vt[i].e_pw, vt[i].e_rv, vt[i].e_crdy, vt[i].e_paddr,
                     vt[i].e_pw ? vt[i].e_pwdata : 8'h00,
                     vt[i].e_rv ? {vt[i].e_re, vt[i].e_rd} : 9'h000};
            chk($sformatf("vec%0d", i), 32'(act_w), 32'(exp_w));
            cmd_valid = vt[i].cv; cmd_write = vt[i].cw; cmd_addr = vt[i].ca; cmd_wdata = vt[i].cd;
            PREADY = vt[i].pr; PRDATA = vt[i].prd; rsp_ready = vt[i].rr;
        end

        // ---- timeout: PREADY held low, then a normal follow-up command ----
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'h77;
        PREADY = 1'b0; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid) break;
            if (PSEL && PENABLE) n_acc++;
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_access_cycles", 32'(n_acc), 32'(TO));
        chk("to_rsp", 32'({rsp_err, rsp_rdata}), 32'({1'b1, 8'h00}));
        chk("to_bus_idle", 32'({PSEL, PENABLE}), 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; PREADY = 1'b1; PRDATA = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) break;
        end
        chk("to_next_valid", 32'(rsp_valid), 32'd1);
        chk("to_next_rsp", 32'({rsp_err, rsp_rdata}), 32'({1'b0, 8'h5A}));

        // ---- FIFO full with response backpressure ----
        setups = 0; n_acc = 0;
        PREADY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) rsp_ready = 1'b0;
            obs_setup();
            if (k == 5) chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
            if (cmd_ready) n_acc++;
            cmd_valid = 1'b1; cmd_write = 1'b1;
            cmd_addr = 8'h40 + 8'(k); cmd_wdata = 8'h80 + 8'(k);
        end
        tick();
        obs_setup();
        cmd_valid = 1'b0;
        chk("full_accepted", 32'(n_acc), 32'd5);
        for (int i = 0; i < 12; i++) begin
            tick();
            obs_setup();
        end
        chk("full_one_xfer", 32'(setups), 32'd1);
        chk("full_rsp_held", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, 8'h00}));
        nrsp = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 80 && nrsp < 5; i++) begin
            tick();
            obs_setup();
            if (rsp_valid) begin
                chk("full_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
                nrsp++;
            end
        end
        chk("full_nrsp", 32'(nrsp), 32'd5);
        chk("full_nsetup", 32'(setups), 32'd5);

        // ---- randomized run against the transaction-level model ----
        for (int i = 0; i < 256; i++) begin
            cmem[i] = 8'($urandom);
            rmem[i] = cmem[i];
        end
        cur_w = 0; acc_cnt = 0; nrsp = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            PREADY = 1'b0;
            PRDATA = 8'($urandom);
            if (PSEL && !PENABLE) begin
                chk("rnd_setup_expected", 32'(acc_q.size() > 0), 32'd1);
                if (acc_q.size() > 0) begin
                    cm = acc_q.pop_front();
                    chk("rnd_setup_cmd", 32'({PWRITE, PADDR, PWRITE ? PWDATA : 8'h00}),
                        32'({cm.w, cm.a, cm.w ? cm.d : 8'h00}));
                    cur_w = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 16 + $urandom_range(0, 4))
                                                        : $urandom_range(0, 3);
                    er.err = (cur_w >= TO);
                    er.rd  = (er.err || cm.w) ? 8'h00 : rmem[cm.a];
                    if (!er.err && cm.w) rmem[cm.a] = cm.d;
                    exp_q.push_back(er);
                end
                acc_cnt = 0;
            end else if (PSEL && PENABLE) begin
                if (acc_cnt == cur_w) begin
                    PREADY = 1'b1;
                    if (PWRITE) cmem[PADDR] = PWDATA;
                    else        PRDATA = cmem[PADDR];
                end
                acc_cnt++;
            end
            chk("rnd_cmd_ready", 32'(cmd_ready), 32'(acc_q.size() < DEPTH));
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    er = exp_q.pop_front();
                    chk("rnd_rsp", 32'({rsp_err, rsp_rdata}), 32'({er.err, er.rd}));
                    nrsp++;
                end
            end
            cmd_valid = (c < 3000) && ($urandom_range(0, 2) == 0);
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom_range(0, 15));
            cmd_wdata = 8'($urandom);
            if (cmd_valid && cmd_ready) begin
                cm.w = cmd_write; cm.a = cmd_addr; cm.d = cmd_wdata;
                acc_q.push_back(cm);
            end
        end
        chk("rnd_drained", 32'(acc_q.size() + exp_q.size()), 32'd0);
        chk("rnd_some_rsp", 32'(nrsp > 100), 32'd1);

        // ---- asynchronous reset in the middle of ACCESS ----
        cmd_valid = 1'b0; rsp_ready = 1'b1; PREADY = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50 + 8'(k);
        end
        tick();
        cmd_valid = 1'b0;
        chk("rst_in_access", 32'({PSEL, PENABLE, cmd_ready}), 32'b111);
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst_async_drop", 32'({PSEL, PENABLE}), 32'd0);
        chk("rst_cmd_ready_during", 32'(cmd_ready), 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_after_idle", 32'({PSEL, rsp_valid, cmd_ready}), 32'b001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
